// File: rtl/stopwatch_control_if.sv
// Button inputs and counter-control outputs of the stopwatch controller,
// bundled so the controller and its environment share one connection.
interface stopwatch_control_if;
  logic       btn_iniciar;   // raw start/stop button, may bounce
  logic       btn_zerar;     // raw zero/lap button, may bounce
  logic       contar_tempo;  // count-enable to the delay counter
  logic       zerar_tempo;   // clear to the delay counter
  logic       congelar;      // lap hold for the display path
  logic [1:0] estado;        // current FSM state for debug/LEDs

  // Environment side: drives the buttons, observes the controls.
  modport master (
    output btn_iniciar, btn_zerar,
    input  contar_tempo, zerar_tempo, congelar, estado
  );

  // Controller side.
  modport slave (
    input  btn_iniciar, btn_zerar,
    output contar_tempo, zerar_tempo, congelar, estado
  );
endinterface

// File: rtl/stopwatch_control.sv
// Stopwatch controller: synchronizes and debounces the two pushbuttons,
// turns each debounced press into a one-clock pulse, and runs a Moore FSM
// that drives the count-enable, clear and lap-hold controls.
module stopwatch_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic               clk,
  input logic               rst_n,
  stopwatch_control_if.slave sw
);

  typedef enum logic [1:0] {
    ZERADO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSADO  = 2'b10,
    VOLTA    = 2'b11
  } state_t;

  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries btn_iniciar, bit 1 carries btn_zerar.
  logic [1:0]       raw;
  logic [1:0]       s1, s2;      // two-flop synchronizer stages
  logic [1:0]       level;       // debounced button levels
  logic [1:0]       level_q;     // previous debounced levels, for edge detect
  logic [1:0]       pulse;       // registered one-clock press pulses
  logic [1:0][19:0] cnt;         // per-button stability counters

  state_t state, state_next;

  assign raw = {sw.btn_zerar, sw.btn_iniciar};

  // Synchronize, debounce and edge-detect both buttons.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      level   <= '0;
      level_q <= '0;
      pulse   <= '0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      // Rising edges only: a release never produces a pulse.
      pulse   <= level & ~level_q;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != level[i]) begin
          // Accept the new level only after it has held for the full window.
          if (cnt[i] == CNT_MAX) begin
            level[i] <= s2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i]   <= cnt[i] + 20'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ZERADO;
    else        state <= state_next;
  end

  // Next-state logic; a start/stop pulse wins and a simultaneous zero/lap
  // pulse is dropped.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    case (state)
      ZERADO: begin
        if (pulse[0]) state_next = CONTANDO;
      end
      CONTANDO: begin
        if (pulse[0])      state_next = PAUSADO;
        else if (pulse[1]) state_next = VOLTA;
      end
      PAUSADO: begin
        if (pulse[0])      state_next = CONTANDO;
        else if (pulse[1]) state_next = ZERADO;
      end
      VOLTA: begin
        if (pulse[0])      state_next = PAUSADO;
        else if (pulse[1]) state_next = CONTANDO;
      end
      default: state_next = ZERADO;
    endcase
  end

  // Moore output decode: controls depend on the state register alone.
  always_comb begin
    sw.contar_tempo = 1'b0;
    sw.zerar_tempo  = 1'b0;
    sw.congelar     = 1'b0;
    case (state)
      ZERADO:   sw.zerar_tempo  = 1'b1;
      CONTANDO: sw.contar_tempo = 1'b1;
      PAUSADO:  ;
      VOLTA: begin
        sw.contar_tempo = 1'b1;
        sw.congelar     = 1'b1;
      end
      default:  sw.zerar_tempo  = 1'b1;
    endcase
  end

  assign sw.estado = state;

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable clocks required to accept a button level (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port btn_iniciar, input, 1 bit: raw start/stop pushbutton, active-high, asynchronous to clk, may bounce.
REQ-005 SHALL have port btn_zerar, input, 1 bit: raw zero/lap pushbutton, active-high, asynchronous to clk, may bounce.
REQ-006 SHALL have port contar_tempo, output, 1 bit: count-enable to the downstream delay counter.
REQ-007 SHALL have port zerar_tempo, output, 1 bit: clear to the downstream delay counter, held high for as long as the counter must stay at 0.
REQ-008 SHALL have port congelar, output, 1 bit: lap hold; when high, the display path freezes the shown value while counting continues.
REQ-009 SHALL have port estado, output, 2 bits: current FSM state (debug/LED).

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL debounce each button separately: a 20-bit counter increments on every clock where s2 != debounced level, and clears on any clock where they match.
REQ-012 SHALL toggle the debounced level, and clear the counter, on the clock where the counter equals DEBOUNCE_CYCLES-1 and s2 still differs; any glitch shorter than DEBOUNCE_CYCLES clocks produces no level change.
REQ-013 SHALL generate a registered one-clock press pulse on each debounced 0->1 transition; 1->0 transitions produce no pulse.
REQ-014 SHALL use a Moore FSM; encodings ZERADO=2'b00, CONTANDO=2'b01, PAUSADO=2'b10, VOLTA=2'b11; estado equals the state register.
REQ-015 SHALL decode outputs from state only: ZERADO -> contar=0, zerar=1, congelar=0; CONTANDO -> 1,0,0; PAUSADO -> 0,0,0; VOLTA -> 1,0,1.
REQ-016 SHALL implement these iniciar-pulse transitions: ZERADO->CONTANDO, CONTANDO->PAUSADO, PAUSADO->CONTANDO, VOLTA->PAUSADO.
REQ-017 SHALL implement these zerar-pulse transitions: PAUSADO->ZERADO, CONTANDO->VOLTA, VOLTA->CONTANDO; in ZERADO, a zerar pulse is ignored.
REQ-018 SHALL give the iniciar pulse priority when both pulses occur on the same clock, with the zerar pulse discarded, not deferred.
REQ-019 SHALL produce end-to-end latency as follows: for a clean raw rise sampled at edge 1, the debounced level rises at edge DEBOUNCE_CYCLES+2, the pulse is high after edge DEBOUNCE_CYCLES+3, and state/outputs change at edge DEBOUNCE_CYCLES+4.
REQ-020 SHALL produce exactly one transition per press, regardless of how long the button is held.
REQ-021 SHALL not alter state on button release.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force state=ZERADO, contar_tempo=0, zerar_tempo=1, congelar=0, and estado=2'b00.
REQ-023 SHALL, while rst_n=0, asynchronously clear the synchronizer flops, debounced levels, debounce counters and pulse registers to 0.
REQ-024 SHALL treat a button already held at reset release as a new press once it has been debounced; it is not suppressed.
REQ-025 SHALL, on reset asserted mid-operation (any state, any partial debounce), discard all in-flight presses, with no pulse emitted after release from pre-reset activity.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-026 SHALL pass: reset, then a clean btn_iniciar press held 20 clocks -> contar_tempo rises at edge 8 after the first sampled-high edge; zerar_tempo falls on the same edge; estado=01; one transition only.
REQ-027 SHALL pass: from CONTANDO, btn_iniciar bouncing 1,0,1,0 with 2-clock periods then stable high -> no state change during the bounce; exactly one transition to PAUSADO (estado=10, contar=0, zerar=0).
REQ-028 SHALL pass: full sequence iniciar, zerar, zerar, iniciar, zerar -> estado 01, 11 (congelar=1, contar=1), 01, 10, 00 (zerar_tempo=1).
REQ-029 SHALL pass: both buttons rising on the same clock from CONTANDO -> PAUSADO, with congelar staying 0.
REQ-030 SHALL pass: rst_n pulled low for 1 clock while in VOLTA with btn_zerar mid-debounce -> outputs immediately return to 0,1,0 and estado=00, with no transition following reset release until a fresh press.
REQ-031 SHALL pass: btn_zerar pressed in ZERADO -> no change (zerar_tempo stays 1, estado=00).
